// File: rtl/axilite_pkg.sv
// Shared types and constants for the AXI-lite slave register file.
// Holds the slave FSM state encoding and the response-error values.
package axilite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_WAIT,
        W_RESP,
        R_WAIT,
        R_RESP
    } axilite_slv_stvec;

    localparam logic RESP_OK     = 1'b0;
    localparam logic RESP_DECERR = 1'b1;

endpackage

// File: rtl/axilite_regfile_mem.sv
// Word array for the AXI-lite register file: synchronous write, registered
// read port with explicit clear, and a full synchronous clear on rst.
module axilite_regfile_mem #(
    parameter int unsigned PARAM_DEPTH = 16,
    parameter int unsigned PARAM_D_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(PARAM_DEPTH)-1:0] wr_idx,
    input  logic [PARAM_D_W-1:0]           wr_data,
    input  logic                           rd_en,
    input  logic                           rd_clr,
    input  logic [$clog2(PARAM_DEPTH)-1:0] rd_idx,
    output logic [PARAM_D_W-1:0]           rd_data
);

    logic [PARAM_D_W-1:0] words [PARAM_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PARAM_DEPTH; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    // Clear wins so the read port reads 0 outside a read response.
    always_ff @(posedge clk) begin
        if (rst || rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= words[rd_idx];
        end
    end

endmodule

// File: rtl/slave_axilite_regfile.sv
// AXI-lite slave register file: single-beat reads/writes with programmable
// wait states before the response, and decode errors for unmapped addresses.
module slave_axilite_regfile
    import axilite_pkg::*;
#(
    parameter int unsigned          PARAM_A_W   = 32,
    parameter int unsigned          PARAM_D_W   = 8,
    parameter int unsigned          PARAM_DEPTH = 16,
    parameter logic [PARAM_A_W-1:0] PARAM_BASE  = '0,
    parameter int unsigned          PARAM_WAIT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 M_LITE_W_ADDRESS_VALID,
    input  logic [PARAM_A_W-1:0] M_LITE_W_ADDRESS,
    input  logic                 M_LITE_W_DATA_VALID,
    input  logic [PARAM_D_W-1:0] M_LITE_W_DATA,
    output logic                 S_LITE_W_ADDRESS_READY,
    output logic                 S_LITE_W_DATA_READY,
    output logic                 S_LITE_W_ACK,
    output logic                 S_LITE_W_ERR,
    input  logic                 M_LITE_W_ACK_READY,
    input  logic                 M_LITE_R_ADDRESS_VALID,
    input  logic [PARAM_A_W-1:0] M_LITE_R_ADDRESS,
    output logic                 S_LITE_R_ADDRESS_READY,
    output logic                 S_LITE_R_ACK,
    output logic [PARAM_D_W-1:0] S_LITE_R_DATA,
    output logic                 S_LITE_R_ERR,
    input  logic                 M_LITE_R_ACK_READY
);

    localparam int unsigned          IDX_W     = $clog2(PARAM_DEPTH);
    localparam int unsigned          WAIT_LOAD = (PARAM_WAIT > 0) ? PARAM_WAIT - 1 : 0;
    localparam int unsigned          CNT_W     = (WAIT_LOAD > 0) ? $clog2(WAIT_LOAD + 1) : 1;
    localparam logic [PARAM_A_W-1:0] DEPTH_A   = PARAM_A_W'(PARAM_DEPTH);

    axilite_slv_stvec     state, next_state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx_q;
    logic                 hit_q;
    logic                 w_ack, w_err, r_ack, r_err;

    logic                 r_ready, w_ready, r_accept, w_accept;
    logic [PARAM_A_W-1:0] acc_addr, acc_off;
    logic                 acc_hit;
    logic [IDX_W-1:0]     acc_idx;
    logic                 cur_hit;
    logic [IDX_W-1:0]     cur_idx;
    logic                 enter_r;

    assign r_ready  = !rst && (state == IDLE);
    assign w_ready  = r_ready && !M_LITE_R_ADDRESS_VALID;
    assign r_accept = r_ready && M_LITE_R_ADDRESS_VALID;
    assign w_accept = w_ready && M_LITE_W_ADDRESS_VALID && M_LITE_W_DATA_VALID;

    assign acc_addr = M_LITE_R_ADDRESS_VALID ? M_LITE_R_ADDRESS : M_LITE_W_ADDRESS;
    assign acc_off  = acc_addr - PARAM_BASE;
    assign acc_hit  = (acc_addr >= PARAM_BASE) && (acc_off < DEPTH_A);
    assign acc_idx  = acc_off[IDX_W-1:0];

    // With zero wait states RESP is entered on the accept edge, before the
    // captured decode exists, so the live decode is used while in IDLE.
    assign cur_hit = (state == IDLE) ? acc_hit : hit_q;
    assign cur_idx = (state == IDLE) ? acc_idx : idx_q;
    assign enter_r = (next_state == R_RESP) && (state != R_RESP);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (r_accept) begin
                    next_state = (PARAM_WAIT > 0) ? R_WAIT : R_RESP;
                end else if (w_accept) begin
                    next_state = (PARAM_WAIT > 0) ? W_WAIT : W_RESP;
                end
            end
            W_WAIT: if (cnt == '0) next_state = W_RESP;
            W_RESP: if (w_ack && M_LITE_W_ACK_READY) next_state = IDLE;
            R_WAIT: if (cnt == '0) next_state = R_RESP;
            R_RESP: if (r_ack && M_LITE_R_ACK_READY) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx_q <= '0;
            hit_q <= 1'b0;
            w_ack <= 1'b0;
            w_err <= RESP_OK;
            r_ack <= 1'b0;
            r_err <= RESP_OK;
        end else begin
            state <= next_state;
            if (r_accept || w_accept) begin
                cnt   <= CNT_W'(WAIT_LOAD);
                idx_q <= acc_idx;
                hit_q <= acc_hit;
            end else if (((state == W_WAIT) || (state == R_WAIT)) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            w_ack <= (next_state == W_RESP);
            w_err <= ((next_state == W_RESP) && !cur_hit) ? RESP_DECERR : RESP_OK;
            r_ack <= (next_state == R_RESP);
            r_err <= ((next_state == R_RESP) && !cur_hit) ? RESP_DECERR : RESP_OK;
        end
    end

    axilite_regfile_mem #(
        .PARAM_DEPTH (PARAM_DEPTH),
        .PARAM_D_W   (PARAM_D_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_accept && acc_hit),
        .wr_idx  (acc_idx),
        .wr_data (M_LITE_W_DATA),
        .rd_en   (enter_r && cur_hit),
        .rd_clr  (next_state != R_RESP),
        .rd_idx  (cur_idx),
        .rd_data (S_LITE_R_DATA)
    );

    assign S_LITE_W_ADDRESS_READY = w_ready;
    assign S_LITE_W_DATA_READY    = w_ready;
    assign S_LITE_R_ADDRESS_READY = r_ready;
    assign S_LITE_W_ACK           = w_ack;
    assign S_LITE_W_ERR           = w_err;
    assign S_LITE_R_ACK           = r_ack;
    assign S_LITE_R_ERR           = r_err;

endmodule

// File: tb/tb_slave_axilite_regfile.sv
// Self-checking bench for slave_axilite_regfile: directed and random
// transactions checked against an array model of the register map.
module tb_slave_axilite_regfile;

    localparam int unsigned A_W   = 32;
    localparam int unsigned D_W   = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BASE  = 32'h10;
    localparam int unsigned WAIT  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           w_av, w_dv, w_ar, w_dr, w_ack, w_err, w_ack_ready;
    logic [A_W-1:0] w_a;
    logic [D_W-1:0] w_d;
    logic           r_av, r_ar, r_ack, r_err, r_ack_ready;
    logic [A_W-1:0] r_a;
    logic [D_W-1:0] r_data;

    int checks = 0;
    int errors = 0;
    logic [D_W-1:0] model [DEPTH];

    always #5 clk = ~clk;

    slave_axilite_regfile #(
        .PARAM_A_W   (A_W),
        .PARAM_D_W   (D_W),
        .PARAM_DEPTH (DEPTH),
        .PARAM_BASE  (A_W'(BASE)),
        .PARAM_WAIT  (WAIT)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .M_LITE_W_ADDRESS_VALID (w_av),
        .M_LITE_W_ADDRESS       (w_a),
        .M_LITE_W_DATA_VALID    (w_dv),
        .M_LITE_W_DATA          (w_d),
        .S_LITE_W_ADDRESS_READY (w_ar),
        .S_LITE_W_DATA_READY    (w_dr),
        .S_LITE_W_ACK           (w_ack),
        .S_LITE_W_ERR           (w_err),
        .M_LITE_W_ACK_READY     (w_ack_ready),
        .M_LITE_R_ADDRESS_VALID (r_av),
        .M_LITE_R_ADDRESS       (r_a),
        .S_LITE_R_ADDRESS_READY (r_ar),
        .S_LITE_R_ACK           (r_ack),
        .S_LITE_R_DATA          (r_data),
        .S_LITE_R_ERR           (r_err),
        .M_LITE_R_ACK_READY     (r_ack_ready)
    );

    function automatic bit mapped(input int unsigned a);
        return (a >= BASE) && (a < BASE + DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: request, latency check, optional backpressure, handshake.
    task automatic do_op(input bit rd, input int unsigned a, input logic [D_W-1:0] d,
                         input int unsigned bp);
        int unsigned    n;
        logic           exp_e;
        logic [D_W-1:0] exp_d;
        @(negedge clk);
        if (rd) begin
            r_av = 1'b1; r_a = A_W'(a);
        end else begin
            w_av = 1'b1; w_dv = 1'b1; w_a = A_W'(a); w_d = d;
        end
        #1;
        chk(rd ? "rd_ready" : "wr_ready", rd ? r_ar : w_ar, 1);
        if (!rd) chk("wr_data_ready", w_dr, 1);
        exp_e = !mapped(a);
        if (!rd && !exp_e) model[a - BASE] = d;
        exp_d = (rd && !exp_e) ? model[a - BASE] : '0;
        @(negedge clk);
        n = 1;
        while (!(rd ? r_ack : w_ack) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(rd ? "rd_latency" : "wr_latency", n, WAIT + 1);
        chk(rd ? "rd_err" : "wr_err", rd ? r_err : w_err, exp_e);
        if (rd) chk("rd_data", r_data, exp_d);
        for (int unsigned i = 0; i < bp; i++) begin
            @(negedge clk);
            chk(rd ? "rd_ack_hold" : "wr_ack_hold", rd ? r_ack : w_ack, 1);
            chk(rd ? "rd_err_hold" : "wr_err_hold", rd ? r_err : w_err, exp_e);
            if (rd) chk("rd_data_hold", r_data, exp_d);
        end
        if (rd) begin
            r_ack_ready = 1'b1; r_av = 1'b0;
        end else begin
            w_ack_ready = 1'b1; w_av = 1'b0; w_dv = 1'b0;
        end
        @(negedge clk);
        r_ack_ready = 1'b0;
        w_ack_ready = 1'b0;
        #1;
        chk(rd ? "rd_ack_done" : "wr_ack_done", rd ? r_ack : w_ack, 0);
        chk(rd ? "rd_err_done" : "wr_err_done", rd ? r_err : w_err, 0);
        chk("rd_data_idle", r_data, 0);
        chk("idle_ready", r_ar, 1);
    endtask

    initial begin
        int unsigned n;
        rst = 1'b1;
        w_av = 1'b1; w_dv = 1'b1; w_a = A_W'(BASE); w_d = 8'hFF; w_ack_ready = 1'b0;
        r_av = 1'b0; r_a = '0; r_ack_ready = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset: held two cycles, readies forced low even with valids up.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_w_ready", w_ar, 0);
        chk("rst_r_ready", r_ar, 0);
        chk("rst_w_ack", w_ack, 0);
        chk("rst_r_ack", r_ack, 0);
        chk("rst_r_data", r_data, 0);
        w_av = 1'b0; w_dv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_w_ready", w_ar, 1);
        chk("post_rst_r_ready", r_ar, 1);
        do_op(1, BASE + 3, 0, 0);

        // Write then read, read with backpressure.
        do_op(0, BASE + 5, 8'hA5, 0);
        do_op(1, BASE + 5, 0, 0);
        do_op(1, BASE + 5, 0, 4);

        // Decode boundaries.
        do_op(0, 32'h08, 8'h77, 0);
        do_op(0, BASE - 1, 8'h11, 0);
        do_op(0, BASE + DEPTH, 8'h22, 1);
        do_op(1, 32'h20, 0, 0);
        do_op(0, BASE, 8'h5C, 0);
        do_op(0, BASE + DEPTH - 1, 8'hC3, 0);
        for (int unsigned i = 0; i < DEPTH; i++) do_op(1, BASE + i, 0, 0);

        // Simultaneous request: read is taken first, write follows.
        @(negedge clk);
        r_av = 1'b1; r_a = A_W'(BASE + 5);
        w_av = 1'b1; w_dv = 1'b1; w_a = A_W'(BASE + 6); w_d = 8'h3C;
        #1;
        chk("sim_r_ready", r_ar, 1);
        chk("sim_w_ready", w_ar, 0);
        chk("sim_w_dready", w_dr, 0);
        @(negedge clk);
        n = 1;
        while (!r_ack && n < 40) begin @(negedge clk); n++; end
        chk("sim_rd_latency", n, WAIT + 1);
        chk("sim_rd_data", r_data, model[5]);
        chk("sim_w_ack_idle", w_ack, 0);
        r_ack_ready = 1'b1; r_av = 1'b0;
        @(negedge clk);
        r_ack_ready = 1'b0;
        #1;
        chk("sim_w_ready_after", w_ar, 1);
        model[6] = 8'h3C;
        @(negedge clk);
        n = 1;
        while (!w_ack && n < 40) begin @(negedge clk); n++; end
        chk("sim_wr_latency", n, WAIT + 1);
        chk("sim_wr_err", w_err, 0);
        w_ack_ready = 1'b1; w_av = 1'b0; w_dv = 1'b0;
        @(negedge clk);
        w_ack_ready = 1'b0;
        do_op(1, BASE + 6, 0, 0);

        // Random traffic around the mapped window.
        for (int unsigned k = 0; k < 40; k++) begin
            do_op(1'($urandom_range(0, 1)), $urandom_range(BASE - 4, BASE + DEPTH + 3),
                  8'($urandom), $urandom_range(0, 3));
        end

        // Reset during a write's wait phase clears the committed word.
        @(negedge clk);
        w_av = 1'b1; w_dv = 1'b1; w_a = A_W'(BASE + 10); w_d = 8'h5A;
        @(negedge clk);
        rst = 1'b1; w_av = 1'b0; w_dv = 1'b0;
        #1;
        chk("mid_rst_r_ready", r_ar, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        chk("mid_rst_w_ack", w_ack, 0);
        do_op(1, BASE + 10, 0, 0);
        do_op(1, BASE + 5, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
